// File: rtl/alu_mc.sv
// Multi-cycle piRISC ALU: single-cycle logic/arith ops plus iterative radix-2
// multiply (low/high) and restoring divide/remainder behind valid/ready handshakes.
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                kill,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out,
    output logic                err,
    output logic                busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(5'b00001);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(5'b10001);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(5'b01001);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5'b01101);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(5'b01111);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(5'b00011);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(5'b01011);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(5'b11011);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(5'b00101);
    localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(5'b00111);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(5'b00010);
    localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(5'b00110);
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(5'b01010);
    localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(5'b01110);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_reg, state_next;
    logic [OP_WIDTH-1:0]   op_reg,    op_next;
    logic [WIDTH-1:0]      opnd_reg,  opnd_next;   // multiplicand or divisor
    logic [WIDTH-1:0]      acc_reg,   acc_next;    // product high half or partial remainder
    logic [WIDTH-1:0]      lo_reg,    lo_next;     // multiplier/product low half or dividend/quotient
    logic [SHAMT_W-1:0]    cnt_reg,   cnt_next;
    logic [WIDTH-1:0]      out_reg,   out_next;
    logic                  err_reg,   err_next;

    logic                  accept;
    logic [SHAMT_W-1:0]    shamt;
    logic [WIDTH-1:0]      alu_res;
    logic                  alu_iter;
    logic                  alu_illegal;

    logic [WIDTH:0]        mul_sum;
    logic [WIDTH-1:0]      mul_acc;
    logic [WIDTH-1:0]      mul_lo;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH:0]        div_diff;
    logic                  div_ge;
    logic [WIDTH-1:0]      div_rem;
    logic [WIDTH-1:0]      div_quo;

    assign in_ready  = !kill && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == BUSY);
    assign out       = out_reg;
    assign err       = err_reg;
    assign shamt     = b[SHAMT_W-1:0];

    // Single-cycle results, evaluated on the live operands at accept time.
    always_comb begin
        alu_res     = '0;
        alu_iter    = 1'b0;
        alu_illegal = 1'b0;
        case (opcode)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_iter = 1'b1;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One shift-add multiply step and one restoring divide step per cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        mul_acc   = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_reg[WIDTH-1:1]};
        div_shift = {acc_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {lo_reg[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        opnd_next  = opnd_reg;
        acc_next   = acc_reg;
        lo_next    = lo_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        err_next   = err_reg;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        op_next  = opcode;
                        err_next = alu_illegal;
                        if (alu_iter) begin
                            state_next = BUSY;
                            cnt_next   = '0;
                            acc_next   = '0;
                            if ((opcode == OP_DIVU) || (opcode == OP_REMU)) begin
                                opnd_next = b;
                                lo_next   = a;
                            end else begin
                                opnd_next = a;
                                lo_next   = b;
                            end
                        end else begin
                            state_next = DONE;
                            out_next   = alu_res;
                        end
                    end else if (state_reg == DONE && out_ready) begin
                        state_next = IDLE;
                    end
                end
                BUSY: begin
                    cnt_next = cnt_reg + SHAMT_W'(1);
                    if ((op_reg == OP_DIVU) || (op_reg == OP_REMU)) begin
                        acc_next = div_rem;
                        lo_next  = div_quo;
                    end else begin
                        acc_next = mul_acc;
                        lo_next  = mul_lo;
                    end
                    if (cnt_reg == SHAMT_W'(WIDTH-1)) begin
                        state_next = DONE;
                        case (op_reg)
                            OP_MUL:   out_next = mul_lo;
                            OP_MULHU: out_next = mul_acc;
                            OP_DIVU:  out_next = div_quo;
                            default:  out_next = div_rem;
                        endcase
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg   <= '0;
            opnd_reg <= '0;
            acc_reg  <= '0;
            lo_reg   <= '0;
            cnt_reg  <= '0;
            out_reg  <= '0;
            err_reg  <= 1'b0;
        end else begin
            op_reg   <= op_next;
            opnd_reg <= opnd_next;
            acc_reg  <= acc_next;
            lo_reg   <= lo_next;
            cnt_reg  <= cnt_next;
            out_reg  <= out_next;
            err_reg  <= err_next;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32): single-cycle ops,
// iterative mul/div timing, backpressure, illegal opcode, kill and async reset.
module tb_alu_mc;
    localparam logic [4:0] ADD   = 5'b00001;
    localparam logic [4:0] SLT   = 5'b00101;
    localparam logic [4:0] SLTU  = 5'b00111;
    localparam logic [4:0] SRA   = 5'b11011;
    localparam logic [4:0] MUL   = 5'b00010;
    localparam logic [4:0] MULHU = 5'b00110;
    localparam logic [4:0] DIVU  = 5'b01010;
    localparam logic [4:0] REMU  = 5'b01110;
    localparam logic [4:0] ILL   = 5'b11111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    alu_mc #(.WIDTH(32), .OP_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("vec %0d %s observed=0x%08h expected=0x%08h", vectors, tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb);
        opcode   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
    endtask

    // Issue an iterative op; latency counts edges from the accept edge inclusive.
    task automatic run_iter(input string tag, input logic [4:0] op, input logic [31:0] va,
                            input logic [31:0] vb, input logic [31:0] exp);
        int lat = 0;
        int busy_cnt = 0;
        int rdy_bad = 0;
        drive(op, va, vb);
        do begin
            tick();
            in_valid = 1'b0;
            lat++;
            if (busy) busy_cnt++;
            if (busy && in_ready) rdy_bad++;
        end while (!out_valid && lat < 100);
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
        chk({tag, "_ready_in_busy"}, 32'(rdy_bad), 32'd0);
        chk({tag, "_out"}, out, exp);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int ov_seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        kill      = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out", out, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops
        drive(ADD, 32'hFFFF_FFFF, 32'h1);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out", out, 32'h0);
        chk("add_in_ready", {31'd0, in_ready}, 32'd1);
        drive(SLT, 32'hFFFF_FFFF, 32'h1);
        tick();
        chk("slt_valid", {31'd0, out_valid}, 32'd1);
        chk("slt_out", out, 32'h1);
        drive(SLTU, 32'hFFFF_FFFF, 32'h1);
        tick();
        chk("sltu_valid", {31'd0, out_valid}, 32'd1);
        chk("sltu_out", out, 32'h0);
        drive(SRA, 32'h8000_0000, 32'h24);
        tick();
        chk("sra_valid", {31'd0, out_valid}, 32'd1);
        chk("sra_out", out, 32'hF800_0000);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Iterative ops, each back-to-back with the previous result
        run_iter("mul",   MUL,   32'h0001_0000, 32'h0001_0000, 32'h0);
        run_iter("mulhu", MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1);
        run_iter("divu",  DIVU,  32'd100, 32'd7, 32'd14);
        run_iter("remu",  REMU,  32'd100, 32'd7, 32'd2);
        run_iter("divu0", DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_iter("remu0", REMU,  32'd5, 32'd0, 32'd5);
        in_valid = 1'b0;
        tick();

        // Backpressure with operand changes during the stall
        out_ready = 1'b0;
        drive(ADD, 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        a = 32'd99;
        b = 32'd99;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out", out, 32'd7);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_done_valid", {31'd0, out_valid}, 32'd0);

        // Illegal opcode, then a legal op clears err
        drive(ILL, 32'h1234_5678, 32'h1);
        tick();
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_out", out, 32'h0);
        chk("ill_err", {31'd0, err}, 32'd1);
        drive(ADD, 32'd2, 32'd3);
        tick();
        chk("post_ill_err", {31'd0, err}, 32'd0);
        chk("post_ill_out", out, 32'd5);
        in_valid = 1'b0;
        tick();

        // kill at cycle 10 of a DIVU
        drive(DIVU, 32'd100, 32'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("kill_pre_busy", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        #1;
        chk("kill_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_valid", {31'd0, out_valid}, 32'd0);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        chk("kill_no_result", 32'(ov_seen), 32'd0);
        chk("kill_idle_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-MUL
        drive(MUL, 32'd6, 32'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out", out, 32'h0);
        chk("arst_err", {31'd0, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(ADD, 32'd10, 32'd20);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_out", out, 32'd30);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor to the combinational piRISC ALU.
- Keeps the existing R-type opcode encodings.
- Adds logical/arithmetic right shifts, unsigned compare, and iterative multiply (low/high) and divide/remainder.
- Uses a valid/ready handshake on both input and output so the execute stage can stall on long operations.
- Sits between the decode/operand-read stage and writeback.

Parameters:
- WIDTH, 32: operand/result width. Power of two, at least 8.
- OP_WIDTH, 5: opcode width.
- SHAMT_W (localparam): $clog2(WIDTH). Number of operand-b bits used as the shift amount.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted this cycle
- opcode  in  OP_WIDTH  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- kill  in  1  synchronous abort of any in-flight or held operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result this cycle
- out  out  WIDTH  registered result
- err  out  1  result came from an illegal opcode (qualified by out_valid)
- busy  out  1  iterative operation in progress

Behaviour:
- Reset (rst_n=0, asynchronous): state goes to IDLE; out=0, out_valid=0, err=0, busy=0; internal operand, accumulator and counter registers cleared. Reset mid-operation discards the operation with no output.
- Opcodes:
  - Single-cycle: ADD 00001, SUB 10001, XOR 01001, OR 01101, AND 01111, SLL 00011, SRL 01011, SRA 11011, SLT 00101 (signed), SLTU 00111.
  - Iterative: MUL 00010 (low WIDTH bits), MULHU 00110 (high WIDTH bits, unsigned), DIVU 01010, REMU 01110.
  - Any other code is illegal: out=0, err=1, single-cycle timing.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready), and is forced 0 when kill=1.
  - opcode, a and b are captured at accept. Later input changes have no effect.
- States:
  - IDLE: on accept of a single-cycle or illegal op, go to DONE with the result registered. On accept of an iterative op, go to BUSY with counter=0.
  - BUSY: busy=1. One radix-2 step per cycle (shift-add multiply, restoring divide), WIDTH steps total. After the last step the result is registered and the state goes to DONE.
  - DONE: out_valid=1. out and err are held stable until out_ready=1. On out_ready, go to IDLE, or accept a new op in the same cycle (back-to-back, no bubble).
- Latency, accept to out_valid:
  - Single-cycle ops: 1 cycle.
  - Iterative ops: WIDTH+1 cycles.
  - Single-cycle throughput: 1 op/cycle while out_ready is held high.
- Arithmetic rules:
  - Results wrap modulo 2^WIDTH; no overflow flag.
  - Shift amount is b[SHAMT_W-1:0]; upper bits of b are ignored.
  - SRA sign-extends from a[WIDTH-1].
  - SLT/SLTU return 1 or 0, zero-extended to WIDTH.
- Divide by zero (b=0): DIVU returns all ones. REMU returns a. Full WIDTH+1 cycle latency still applies; err=0.
- kill=1 (synchronous, any state): next state is IDLE, out_valid=0, busy=0, and any held result is dropped. kill has priority over accept and over out_ready.
- out keeps its last value after a handshake (don't-care while out_valid=0). err is cleared on every accept.

Test Plan:
- Reset, then ADD a=0xFFFF_FFFF, b=0x1 with out_ready=1 -> out_valid one cycle after accept, out=0x0. Follow with SLT and SLTU, both with a=0xFFFF_FFFF, b=0x1 -> 1 then 0. Follow with SRA a=0x8000_0000, b=0x24 -> 0xF800_0000 (shamt 4). All issued back-to-back, one result per cycle.
- MUL then MULHU, both with a=0x0001_0000, b=0x0001_0000 -> out=0x0 then out=0x1. Each out_valid exactly 33 cycles after its accept; busy=1 for 32 cycles; in_ready=0 throughout BUSY.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5. err=0 in all cases.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> out_valid and out=7 held stable, in_ready=0. Change a/b during the stall -> out unchanged. out_ready=1 -> completes, with in_ready=1 in the same cycle.
- Illegal opcode 11111 -> out=0, err=1 after 1 cycle. The next legal op clears err.
- kill asserted at cycle 10 of a DIVU -> IDLE next cycle, no out_valid. Separately, rst_n pulsed low mid-MUL -> all outputs 0 immediately (asynchronous); the next ADD after reset behaves normally.
